// File: rtl/fibonacci_engine.sv
// Iterative Fibonacci/Lucas term generator: s(n) mod 2^WIDTH plus a sticky overflow flag.
// Latency n+1 cycles in COMPUTE; start is ignored while busy, accepted in IDLE or DONE.
module fibonacci_engine #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [IDX_W-1:0] index,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] term_a, term_b;
  logic             flag_a, flag_b;
  logic [IDX_W-1:0] cnt, idx_q;
  logic [WIDTH:0]   sum;
  logic             accept, finish;

  assign sum = {1'b0, term_a} + {1'b0, term_b};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        // Compare before increment so the maximum index never wraps the counter.
        if (cnt == idx_q) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = COMPUTE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == COMPUTE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      term_a   <= '0;
      term_b   <= '0;
      flag_a   <= 1'b0;
      flag_b   <= 1'b0;
      cnt      <= '0;
      idx_q    <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      // The mode is consumed here: it only selects the seed pair.
      idx_q  <= index;
      term_a <= mode ? WIDTH'(2) : '0;
      term_b <= WIDTH'(1);
      flag_a <= 1'b0;
      flag_b <= 1'b0;
      cnt    <= '0;
    end else if (state == COMPUTE) begin
      if (finish) begin
        result   <= term_a;
        overflow <= flag_a;
      end else begin
        term_a <= term_b;
        term_b <= sum[WIDTH-1:0];
        flag_a <= flag_b;
        flag_b <= flag_a | flag_b | sum[WIDTH];
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_engine.sv
// Directed bench for fibonacci_engine (WIDTH=16, IDX_W=5) with hand-computed terms.
module tb_fibonacci_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [4:0]  index;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  fibonacci_engine #(.WIDTH(16), .IDX_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .index    (index),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive a start pulse; returns at the negedge after the accepting edge.
  task automatic accept_req(input logic m, input logic [4:0] n);
    start = 1'b1;
    mode  = m;
    index = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called one negedge after the accepting edge; returns in the done cycle.
  task automatic wait_done(input int n, input logic [15:0] exp_res, input logic exp_ovf);
    int          lat;
    int          bcnt;
    logic [15:0] held;
    logic        moved;
    held  = result;
    bcnt  = busy ? 1 : 0;
    lat   = 0;
    moved = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (!done && result !== held) moved = 1'b1;
    end
    check("latency", lat, n + 1);
    check("busy_cycles", bcnt, n + 1);
    check("result", result, exp_res);
    check("overflow", overflow, exp_ovf);
    check("result_held", moved, 0);
  endtask

  task automatic run_case(input logic m, input logic [4:0] n, input logic [15:0] exp_res,
                          input logic exp_ovf);
    accept_req(m, n);
    wait_done(n, exp_res, exp_ovf);
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  typedef struct {
    logic        m;
    logic [4:0]  n;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[10] = '{
    '{1'b0, 5'd10, 16'd55,    1'b0},
    '{1'b0, 5'd0,  16'd0,     1'b0},
    '{1'b1, 5'd0,  16'd2,     1'b0},
    '{1'b0, 5'd1,  16'd1,     1'b0},
    '{1'b1, 5'd5,  16'd11,    1'b0},
    '{1'b0, 5'd24, 16'd46368, 1'b0},
    '{1'b0, 5'd25, 16'd9489,  1'b1},
    '{1'b1, 5'd23, 16'd64079, 1'b0},
    '{1'b1, 5'd24, 16'd38146, 1'b1},
    '{1'b0, 5'd31, 16'd35549, 1'b1}
  };

  initial begin
    int   k;
    logic seen;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    index = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_case(vecs[i].m, vecs[i].n, vecs[i].res, vecs[i].ovf);

    // Start/index/mode changes during COMPUTE are ignored.
    accept_req(1'b0, 5'd10);
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    index = 5'd3;
    repeat (3) @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ignore_done_seen", done, 1);
    check("ignore_result", result, 55);

    // Start in the DONE cycle is accepted back-to-back.
    start = 1'b1;
    mode  = 1'b1;
    index = 5'd5;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(5, 16'd11, 1'b0);
    @(negedge clk);

    // Reset beats start in the same cycle; start accepted right after.
    reset = 1'b1;
    start = 1'b1;
    mode  = 1'b0;
    index = 5'd7;
    @(negedge clk);
    check("reset_prio_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("accept_after_reset", busy, 1);
    wait_done(7, 16'd13, 1'b0);
    @(negedge clk);

    // Reset mid-COMPUTE clears everything with no done pulse.
    accept_req(1'b0, 5'd20);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_result", result, 0);
    check("midreset_overflow", overflow, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midreset_quiet", seen, 0);
    run_case(1'b0, 5'd20, 16'd6765, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fibonacci_engine.md
FIBONACCI_ENGINE -- requirements
Module: fibonacci_engine

Interface
REQ-001 Parameter WIDTH, default 16, result and datapath width in bits; legal range 2..64.
REQ-002 Parameter IDX_W, default 5, width of the sequence index; legal range 1..8.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to compute; sampled only in IDLE or DONE.
REQ-006 mode  input  1  sequence select: 0 = Fibonacci (s0=0, s1=1), 1 = Lucas (s0=2, s1=1).
REQ-007 index  input  IDX_W  unsigned index n of the requested term s(n).
REQ-008 busy  output  1  high while in COMPUTE.
REQ-009 done  output  1  single-cycle pulse when result and overflow are valid.
REQ-010 result  output  WIDTH  s(n) mod 2^WIDTH.
REQ-011 overflow  output  1  high when true s(n) >= 2^WIDTH.

Function
REQ-012 The FSM SHALL have three states: IDLE, COMPUTE and DONE.
REQ-013 IDLE->COMPUTE when start=1; IDLE holds otherwise.
REQ-014 On the accepting edge, index and mode SHALL be captured internally, the term registers loaded with (s0, s1) per mode, and the iteration counter cleared to 0.
REQ-015 In COMPUTE, if counter == captured index, go to DONE and register result=a and overflow=flag(a); otherwise a<=b, b<=a+b (WIDTH-bit wrap), counter<=counter+1.
REQ-016 Each term register SHALL carry a sticky overflow flag: new b flag = a flag | b flag | carry-out of a+b; the a flag takes the old b flag.
REQ-017 Latency: start sampled at edge k -> done=1 in the cycle after edge k+n+1 (n+1 cycles after the start cycle); n=0 gives done one cycle after start.
REQ-018 DONE lasts exactly one cycle; DONE->COMPUTE if start=1 (back-to-back accept, same capture as REQ-014), else DONE->IDLE.
REQ-019 start, index and mode SHALL be ignored while in COMPUTE; changing them mid-computation has no effect.
REQ-020 result and overflow SHALL hold their last DONE values until the next DONE; they do not change during COMPUTE.
REQ-021 busy=1 exactly in COMPUTE; done=1 exactly in DONE.
REQ-022 The maximum index (2^IDX_W - 1) SHALL be handled without counter wrap-around; compare before increment.

Reset
REQ-023 reset=1 at any edge SHALL force IDLE, busy=0, done=0, result=0 and overflow=0, and clear counter, terms, flags and captured fields, including mid-COMPUTE.
REQ-024 reset SHALL take priority over start in the same cycle; the first start is accepted on the first edge after reset deasserts.

Verification
REQ-025 mode=0, index=10, start pulse -> done 11 cycles later, result=55, overflow=0, busy high for 11 cycles.
REQ-026 index=0: mode=0 -> result=0; mode=1 -> result=2; each with done one cycle after start.
REQ-027 WIDTH=16, mode=0: index=24 -> 46368, overflow=0; index=25 -> 9489, overflow=1.
REQ-028 WIDTH=16, mode=1: index=23 -> 64079, overflow=0; index=24 -> 38146, overflow=1.
REQ-029 start with index=3 while busy -> ignored, first result intact; start asserted in the DONE cycle -> accepted, busy next cycle.
REQ-030 reset asserted mid-COMPUTE at index=20 -> next cycle IDLE, all outputs 0, no done pulse; a new start then completes normally.
